// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types, constants and helpers for the BCD counter family.
//   bcd_digit_t   - one packed BCD digit (4 bits)
//   bcd_sane_t    - a sanitized digit plus a flag saying the source nibble
//                   was not a legal BCD code
//   BCD_MAX/MIN   - the digit values that trigger carry / borrow
//   bcd_sanitize  - maps A..F to 0 and reports them as invalid
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    logic       invalid;
    bcd_digit_t digit;
  } bcd_sane_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_sane_t bcd_sanitize(input bcd_digit_t nib);
    bcd_sane_t res;
    if (nib > BCD_MAX) begin
      res.invalid = 1'b1;
      res.digit   = BCD_MIN;
    end else begin
      res.invalid = 1'b0;
      res.digit   = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: one BCD digit register with wrap-around step.
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   step        - advance this digit by one on the next edge
//   up          - step direction: 1 = +1 (9 wraps to 0), 0 = -1 (0 wraps to 9)
//   load        - take load_digit on the next edge (overrides step)
//   load_digit  - already-sanitized BCD digit to load
//   digit       - current registered digit
//   at_max      - digit == 9 (carry condition for higher digits)
//   at_min      - digit == 0 (borrow condition for higher digits)
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_digit,
  output logic [3:0] digit,
  output logic       at_max,
  output logic       at_min
);

  bcd_digit_t digit_r;
  bcd_digit_t digit_next;

  // Only legal BCD values can ever be produced: 9 and 0 wrap explicitly
  // instead of relying on 4-bit overflow.
  always_comb begin
    digit_next = digit_r;
    if (load) begin
      digit_next = load_digit;
    end else if (step) begin
      if (up) begin
        digit_next = (digit_r == BCD_MAX) ? BCD_MIN : digit_r + 4'd1;
      end else begin
        digit_next = (digit_r == BCD_MIN) ? BCD_MAX : digit_r - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_r <= BCD_MIN;
    end else begin
      digit_r <= digit_next;
    end
  end

  assign digit  = digit_r;
  assign at_max = (digit_r == BCD_MAX);
  assign at_min = (digit_r == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: DIGITS-digit BCD up/down counter with parallel load,
// terminal count and wrap reporting.
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   en          - count enable, one step per cycle
//   up          - 1 = increment, 0 = decrement (no pipeline, takes effect now)
//   load        - parallel load strobe, wins over en
//   load_val    - BCD value to load, digit i at [4i+3:4i]; A..F load as 0
//   q           - registered count, digit 0 least significant
//   ena         - combinational step strobes of digits 1..DIGITS-1;
//                 bit j is the strobe for digit j+1. With DIGITS=1 there
//                 are no upper digits and the single bit is tied to 0.
//   tc          - combinational terminal count (next step wraps)
//   wrap        - registered pulse, the cycle after a wrap edge
//   load_err    - registered pulse, the cycle after a load with A..F nibbles
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  localparam int ENA_W = (DIGITS > 1) ? DIGITS - 1 : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic [ENA_W-1:0]      ena,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] nib_invalid;
  // all_max[i] / all_min[i]: every digit below i is 9 / 0.
  // Index DIGITS covers the whole count and feeds tc.
  logic [DIGITS:0]   all_max;
  logic [DIGITS:0]   all_min;
  logic              count_ok;
  logic              wrap_r;
  logic              load_err_r;

  assign count_ok   = en & ~load;
  assign all_max[0] = 1'b1;
  assign all_min[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_sane_t sane;

    assign sane           = bcd_sanitize(load_val[4*i +: 4]);
    assign nib_invalid[i] = sane.invalid;
    assign all_max[i+1]   = all_max[i] & at_max[i];
    assign all_min[i+1]   = all_min[i] & at_min[i];
    assign step[i]        = count_ok & (up ? all_max[i] : all_min[i]);

    bcd_digit_cell u_cell (
      .clk        (clk),
      .reset      (reset),
      .step       (step[i]),
      .up         (up),
      .load       (load),
      .load_digit (sane.digit),
      .digit      (q[4*i +: 4]),
      .at_max     (at_max[i]),
      .at_min     (at_min[i])
    );
  end

  if (DIGITS > 1) begin : g_ena
    assign ena = step[DIGITS-1:1];
  end else begin : g_no_ena
    assign ena = 1'b0;
  end

  // tc already includes ~load, so a load cycle can never report a wrap.
  assign tc = count_ok & (up ? all_max[DIGITS] : all_min[DIGITS]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      wrap_r     <= tc;
      load_err_r <= load & (|nib_invalid);
    end
  end

  assign wrap     = wrap_r;
  assign load_err = load_err_r;

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
Parametrised N-digit synchronous BCD counter with count enable, up/down direction, parallel load and wrap reporting. Generation-two replacement for the fixed 4-digit up-only BCD counter: digit count is a parameter, and direction, load, terminal-count and error signalling are added. Used as a decade timebase or event counter feeding display and timer logic.

Parameters:
DIGITS, 4, number of BCD digits (legal range 1..8); q width is 4*DIGITS.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state immediately
en  input  1  count enable; one step per cycle while high
up  input  1  direction: 1 = increment, 0 = decrement; sampled each cycle
load  input  1  parallel load strobe
load_val  input  4*DIGITS  BCD value to load, digit i at [4i+3:4i]
q  output  4*DIGITS  registered count, digit 0 = least significant
ena  output  DIGITS-1 (bits [DIGITS-1:1]; absent when DIGITS=1)  combinational per-digit step strobes
tc  output  1  combinational terminal count
wrap  output  1  registered one-cycle wrap pulse
load_err  output  1  registered one-cycle invalid-load pulse

Behaviour:
- Reset, asynchronous: q=0, wrap=0, load_err=0. ena and tc then follow from q.
- Priority, per cycle: reset > load > en > hold.
- Load (load=1): each digit of q takes its load_val digit on the next edge.
  - A nibble in the range A..F loads as 0.
  - load_err=1 on the next cycle if any nibble was invalid, else 0.
  - en is ignored that cycle and wrap=0.
- Up count (en=1, up=1, load=0):
  - Digit 0 always steps; digit i steps when all digits below i equal 9.
  - A stepping digit goes to d+1, or 9 -> 0.
- Down count (en=1, up=0, load=0):
  - Digit i steps when all digits below i equal 0.
  - A stepping digit goes to d-1, or 0 -> 9.
- ena[i] = en & ~load & (up ? all lower digits == 9 : all lower digits == 0), for i = 1..DIGITS-1.
- tc = en & ~load & (up ? q == all 9s : q == 0).
- wrap = 1 on the cycle after an edge where tc=1, i.e. 99..9 -> 00..0 or 00..0 -> 99..9. Otherwise 0.
- wrap and load_err are 0 in every cycle not described above.
- Direction change is effective immediately; there is no pipeline.
- Latency: q updates on the edge after stimulus; ena/tc are same-cycle combinational from the registered q.
- en=0 with load=0: q holds; ena=0, tc=0.
- Reset asserted mid-count or mid-load: state clears asynchronously. The first count after release starts from 0.
- q never holds a non-BCD nibble. No arithmetic beyond 4-bit per-digit compare and increment/decrement.

Decomposition:
- Shared package bcd_pkg holds:
  - typedef bcd_digit_t (logic [3:0])
  - constants BCD_MAX=4'd9, BCD_MIN=4'd0
  - function bcd_sanitize (A..F -> 0, plus an invalid flag)
- One sub-module, bcd_digit_cell, holds one digit register with async reset and inputs step, up, load, load_digit.
  - Outputs: digit, at_max, at_min.
  - Generated DIGITS times, with the ena/tc chains built from the at_max/at_min outputs in the top level.

Test Plan:
- DIGITS=4; reset held high mid-count at q=0x0537, then released -> q=0x0000 immediately; wrap=0, load_err=0; counting resumes 0x0001, 0x0002.
- Load 0x0999, en=1, up=1 -> during that cycle ena=3'b111, tc=0; next q=0x1000.
- Load 0x1000, en=1, up=0 -> ena=3'b111; next q=0x0999.
- Load 0x9999, en=1, up=1 -> tc=1; next q=0x0000 and wrap=1 for one cycle. Symmetric case: 0x0000 with up=0 -> 0x9999, wrap=1.
- load=1, load_val=0x12F4, en=1 in the same cycle -> q=0x1204, load_err=1 for one cycle, no count step, wrap=0.
- DIGITS=1; count up 0..9 -> wrap after 9 -> 0; toggle up mid-sequence at q=5 -> next q=4.
